// File: rtl/move_serializer.sv
// Serializes a legal-target bitboard into one (from, to) move per accepted handshake.
// Optional build macro MOVE_SERIALIZER_CAPTURE_FLAG_EN enables the move_capture flag.
module move_serializer #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clock,
  input  logic        initialize,
  input  logic        load,
  input  logic [5:0]  from_square,
  input  logic [63:0] move_wires,
  input  logic [63:0] is_occupied_wires,
  output logic        move_valid,
  input  logic        move_ready,
  output logic [5:0]  move_from,
  output logic [5:0]  move_to,
  output logic        move_last,
  output logic        move_capture,
  output logic        busy,
  output logic        done,
  output logic [6:0]  move_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pending_q, pending_d;
  logic [5:0]  from_q, from_d;
  logic [6:0]  count_q, count_d;
  logic [5:0]  to_idx;

  // Priority encoder: the last match in loop order wins, so the loop runs
  // away from the square that should be emitted first.
  always_comb begin
    to_idx = 6'd0;
    if (LSB_FIRST) begin
      for (int i = 63; i >= 0; i--) begin
        if (pending_q[i]) to_idx = 6'(i);
      end
    end else begin
      for (int i = 0; i < 64; i++) begin
        if (pending_q[i]) to_idx = 6'(i);
      end
    end
  end

  assign move_valid = (state_q == EMIT);
  assign move_to    = to_idx;
  assign move_from  = from_q;
  assign move_last  = (pending_q != 64'd0) && ((pending_q & (pending_q - 64'd1)) == 64'd0);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign move_count = count_q;

`ifdef MOVE_SERIALIZER_CAPTURE_FLAG_EN
  assign move_capture = move_valid & is_occupied_wires[to_idx];
`else
  logic unused_occupied;
  assign unused_occupied = ^is_occupied_wires;
  assign move_capture    = 1'b0;
`endif

  // NOTE: every always_comb target gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    from_d    = from_q;
    count_d   = count_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          pending_d = move_wires;
          from_d    = from_square;
          count_d   = 7'd0;
          state_d   = (move_wires == 64'd0) ? DONE : EMIT;
        end
      end
      EMIT: begin
        if (move_ready) begin
          pending_d[to_idx] = 1'b0;
          count_d           = count_q + 7'd1;
          if (move_last) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock or posedge initialize) begin
    if (initialize) begin
      state_q   <= IDLE;
      pending_q <= 64'd0;
      from_q    <= 6'd0;
      count_q   <= 7'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      from_q    <= from_d;
      count_q   <= count_d;
    end
  end

endmodule
